seq_1010_tx: RTL
================

# seq_1010_tx

Serial frame transmitter that produces the bit stream consumed by the 1010 Moore sequence detector. Each accepted parallel word is sent as a 4-bit sync preamble `1010`, followed by the payload MSB-first, one bit per clock. An optional parity bit follows the payload. It sits upstream of the detector's `x` input and is used both as a stimulus source and as the transmit end of the serial link.

## Interface
Parameters:
- `WIDTH`, default 8: payload width in bits, minimum 1.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `din`, input, WIDTH: payload word; sampled only on the accept edge.
- `din_valid`, input, 1: a payload word is offered.
- `din_ready`, output, 1: the block can accept a word (registered).
- `dout`, output, 1: serial bit, drives the detector `x` (registered).
- `dout_en`, output, 1: high while `dout` carries a frame bit (registered).
- `cst`, output, 2: current state, for debug and observation (registered).

## Operation
- States and `cst` encodings:
  - IDLE = 0
  - SYNC = 1
  - DATA = 2
  - PAR = 3
- Reset values at the reset edge:
  - `cst` = IDLE, `dout` = 0, `dout_en` = 0, `din_ready` = 1.
  - Shift register and bit counter cleared.
- IDLE:
  - `din_ready` = 1, `dout_en` = 0, `dout` = 0.
  - Accept occurs on an edge with `din_valid && din_ready`. On that edge: capture `din`, go to SYNC, and drive the first sync bit.
- SYNC: 4 cycles, `dout` = 1, 0, 1, 0 in order, then DATA.
- DATA: WIDTH cycles, `dout` = captured `din[WIDTH-1]` down to `din[0]`.
  - After the last bit: go to PAR if parity is compiled in, otherwise IDLE.
- PAR: 1 cycle, `dout` = XOR of all captured payload bits (even parity), then IDLE.
- Inside a frame (SYNC, DATA, PAR): `dout_en` = 1 and `din_ready` = 0.
- `din_valid` outside IDLE is ignored. Changes on `din` after the accept edge do not affect the frame in flight.
- Payload bits that happen to contain `1010` are not escaped. Framing above the bit level is the consumer's concern.
- Reset mid-frame: the frame is aborted at the reset edge, all outputs take their reset values, and no partial bits follow.
- `rst` and `din_valid` high on the same edge: reset wins and no word is accepted.

## Timing
- Frame length: L = 4 + WIDTH, plus 1 when parity is enabled.
- Accept at edge N:
  - `dout_en` rises at edge N.
  - The first sync bit (1) is valid from edge N to edge N+1.
- `dout_en` is high for exactly L consecutive cycles and falls at edge N+L. `din_ready` rises at that same edge.
- Minimum gap between frames is one IDLE cycle:
  - earliest next accept is edge N+L+1;
  - back-to-back frame period is L+1 cycles.
- The bit counter spans at least clog2(max(4, WIDTH)) bits. It is compared against `WIDTH-1`, so no wrap occurs inside a state.

## Configuration
- Macro `SEQ_1010_TX_PARITY_EN`:
  - Defined: PAR state present, L = 5 + WIDTH.
  - Undefined: the PAR state is never entered, DATA returns directly to IDLE, and L = 4 + WIDTH.
  - The `cst` encoding of the other states is unchanged either way.

## Structure
- Package `seq_1010_pkg` holds:
  - state enum/localparams (IDLE, SYNC, DATA, PAR, 2-bit);
  - `SYNC_PATTERN` = 4'b1010 and `SYNC_LEN` = 4.
  - The detector shares the same package.
- Sub-module `piso_shift` (parameter WIDTH) covers:
  - parallel load on accept;
  - left shift per DATA cycle, with MSB as the serial output;
  - running XOR for parity.
- The top level holds the FSM, counter and output registers.

## Test plan
- Reset then idle, `din_valid` = 0 for 10 cycles:
  - `dout` = 0, `dout_en` = 0, `din_ready` = 1, `cst` = 0 throughout.
- WIDTH = 8, `din` = 8'hC3 offered for one cycle:
  - `dout` = 1010_11000011, then parity 0 if enabled.
  - `dout_en` high 12 or 13 cycles, `din_ready` low for the same span.
- `din_valid` held high with 8'hA5 then 8'h01:
  - Two frames separated by exactly one `dout_en` = 0 cycle.
  - Parity bits 0 and 1 when enabled.
  - Second word sampled only at its accept edge.
- `rst` asserted on the 3rd DATA cycle:
  - Next cycle `dout_en` = 0, `cst` = 0, `din_ready` = 1.
  - A new word is accepted on the following edge and its frame starts with sync bit 1.
- `din` toggled every cycle during a frame, and `din_valid` pulsed mid-frame:
  - Transmitted payload equals the value captured at the accept edge.
  - No extra frame is started.
- Loopback of `dout` into the 1010 detector with payload 8'h00:
  - The detector `out` pulses exactly once per frame, caused by the preamble.

Source files
------------

// File: rtl/seq_1010_pkg.sv
// Shared definitions for the 1010 serial link: FSM state encoding and sync preamble.
// Used by both the transmitter (seq_1010_tx) and the 1010 detector.
package seq_1010_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      DATA = 2'd2,
      PAR  = 2'd3
   } state_e;

   localparam int unsigned             SYNC_LEN     = 4;
   localparam logic [SYNC_LEN-1:0]     SYNC_PATTERN = 4'b1010;

   // Bit counter must index both the preamble and the payload without wrapping.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width > SYNC_LEN ? width : SYNC_LEN);
   endfunction

endpackage

// File: rtl/seq_1010_tx_piso_shift.sv
// Parallel-in serial-out payload register for seq_1010_tx: load, MSB-first shift,
// and a running even-parity XOR when SEQ_1010_TX_PARITY_EN is defined.
module piso_shift #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] din_i,
`ifdef SEQ_1010_TX_PARITY_EN
   output logic             par_o,
`endif
   output logic             msb_o
);

   logic [WIDTH-1:0] sreg_q, sreg_d;

   always_comb begin
      sreg_d = sreg_q;
      if (load_i)       sreg_d = din_i;
      else if (shift_i) sreg_d = sreg_q << 1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) sreg_q <= '0;
      else     sreg_q <= sreg_d;
   end

   assign msb_o = sreg_q[WIDTH-1];

`ifdef SEQ_1010_TX_PARITY_EN
   logic par_q, par_d;

   // Accumulates each bit as it leaves, so after the last shift it holds XOR of the whole word.
   always_comb begin
      par_d = par_q;
      if (load_i)       par_d = 1'b0;
      else if (shift_i) par_d = par_q ^ sreg_q[WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (rst) par_q <= 1'b0;
      else     par_q <= par_d;
   end

   assign par_o = par_q;
`endif

endmodule

// File: rtl/seq_1010_tx.sv
// Serial frame transmitter: 1010 preamble, payload MSB-first, optional even parity.
// Parity bit is compiled in with `define SEQ_1010_TX_PARITY_EN.
module seq_1010_tx
   import seq_1010_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             dout,
   output logic             dout_en,
   output logic [1:0]       cst
);

   localparam int unsigned      CNT_W     = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dout_q, dout_d;
   logic             dout_en_q, dout_en_d;
   logic             din_ready_q, din_ready_d;
   logic             accept, shift, msb;
   logic [1:0]       sync_idx;

   assign accept   = din_valid && din_ready_q;
   // Preamble bit 0 goes out on the accept edge; counter value c selects bit c+1.
   assign sync_idx = 2'(SYNC_LEN - 2) - cnt_q[1:0];

`ifdef SEQ_1010_TX_PARITY_EN
   logic par;
`endif

   piso_shift #(.WIDTH(WIDTH)) u_piso (
      .clk     (clk),
      .rst     (rst),
      .load_i  (accept),
      .shift_i (shift),
      .din_i   (din),
`ifdef SEQ_1010_TX_PARITY_EN
      .par_o   (par),
`endif
      .msb_o   (msb)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dout_d      = 1'b0;
      dout_en_d   = 1'b1;
      din_ready_d = 1'b0;
      shift       = 1'b0;
      case (state_q)
         IDLE: begin
            dout_en_d   = 1'b0;
            din_ready_d = 1'b1;
            if (accept) begin
               state_d     = SYNC;
               cnt_d       = '0;
               dout_d      = SYNC_PATTERN[SYNC_LEN-1];
               dout_en_d   = 1'b1;
               din_ready_d = 1'b0;
            end
         end
         SYNC: begin
            if (cnt_q == SYNC_LAST) begin
               state_d = DATA;
               cnt_d   = '0;
               dout_d  = msb;
               shift   = 1'b1;
            end else begin
               cnt_d  = cnt_q + 1'b1;
               dout_d = SYNC_PATTERN[sync_idx];
            end
         end
         DATA: begin
            if (cnt_q == DATA_LAST) begin
               cnt_d = '0;
`ifdef SEQ_1010_TX_PARITY_EN
               state_d = PAR;
               dout_d  = par;
`else
               state_d     = IDLE;
               dout_en_d   = 1'b0;
               din_ready_d = 1'b1;
`endif
            end else begin
               cnt_d  = cnt_q + 1'b1;
               dout_d = msb;
               shift  = 1'b1;
            end
         end
         PAR: begin
            state_d     = IDLE;
            cnt_d       = '0;
            dout_en_d   = 1'b0;
            din_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dout_q      <= 1'b0;
         dout_en_q   <= 1'b0;
         din_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dout_q      <= dout_d;
         dout_en_q   <= dout_en_d;
         din_ready_q <= din_ready_d;
      end
   end

   assign dout      = dout_q;
   assign dout_en   = dout_en_q;
   assign din_ready = din_ready_q;
   assign cst       = state_q;

endmodule
